cp0: RTL and testbench

Coprocessor-0 exception/interrupt controller for the P7 pipelined MIPS CPU. It consumes the Timer IRQ lines and the external interrupt line as HWInt[7:2], and the exception code from the pipeline's commit point (M stage). It decides when to take an exception or interrupt and records SR, Cause and EPC. It also serves mfc0/mtc0/eret.

---
 rtl/cp0.sv | 77 +++++++
 tb/tb_cp0.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cp0.sv
// cp0: MIPS coprocessor-0 exception/interrupt controller (SR, Cause, EPC, PRId; optional BadVAddr via CP0_BADVADDR_EN)
module cp0 #(
  parameter logic [31:0] PRID = 32'h0000_7007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [29:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [31:0] VAddr,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [29:0] EPC,
  output logic [31:0] Dout
);
  logic [5:0] im, ip;
  logic exl, ie, bd_r;
  logic [4:0] exc_r;
  logic [29:0] epc_r;
  logic irq_int, irq_exc;
  logic [31:0] bva_rd;
  assign irq_int = |(HWInt & im) & ie & ~exl;
  assign irq_exc = (ExcCode != 5'd0) & ~exl;
  assign IntReq = irq_int | irq_exc;
  assign EPC = epc_r;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      im <= '0;
      ip <= '0;
      exl <= 1'b0;
      ie <= 1'b0;
      bd_r <= 1'b0;
      exc_r <= '0;
      epc_r <= '0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        exl <= 1'b1;
        bd_r <= BD;
        exc_r <= irq_int ? 5'd0 : ExcCode;
        epc_r <= BD ? PC - 30'd1 : PC;
      end else begin
        if (WE && A2 == 5'd12) begin
          im <= Din[15:10];
          exl <= Din[1] & ~EXLClr;
          ie <= Din[0];
        end else if (EXLClr)
          exl <= 1'b0;
        if (WE && A2 == 5'd14)
          epc_r <= Din[31:2];
      end
    end
`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr;
  always_ff @(posedge clk or posedge reset)
    if (reset)
      badvaddr <= '0;
    else if (IntReq && !irq_int && (ExcCode == 5'd4 || ExcCode == 5'd5))
      badvaddr <= VAddr;
  assign bva_rd = badvaddr;
`else
  logic unused_vaddr;
  assign unused_vaddr = ^VAddr;
  assign bva_rd = '0;
`endif
  always_comb
    Dout = A1 == 5'd12 ? {16'b0, im, 8'b0, exl, ie} :
           A1 == 5'd13 ? {bd_r, 15'b0, ip, 3'b0, exc_r, 2'b0} :
           A1 == 5'd14 ? {epc_r, 2'b00} :
           A1 == 5'd15 ? PRID :
           A1 == 5'd8  ? bva_rd : 32'd0;
endmodule

// File: tb/tb_cp0.sv
// tb_cp0: scoreboard-driven self-checking bench for cp0
module tb_cp0;
  localparam logic [31:0] PRID = 32'h0000_7007;
`ifdef CP0_BADVADDR_EN
  localparam logic [31:0] BVA = 32'h0000_7F0B;
`else
  localparam logic [31:0] BVA = 32'h0000_0000;
`endif
  logic clk = 0, reset = 1;
  logic [4:0] A1 = 0, A2 = 0, ExcCode = 0;
  logic [31:0] Din = 0, VAddr = 0;
  logic WE = 0, BD = 0, EXLClr = 0;
  logic [29:0] PC = 0;
  logic [5:0] HWInt = 0;
  logic IntReq;
  logic [29:0] EPC;
  logic [31:0] Dout;
  int checks = 0, errors = 0;
  typedef struct { logic [4:0] a; logic [31:0] v; string n; } exp_t;
  exp_t sb[$];
  cp0 #(.PRID(PRID)) dut (.clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .WE(WE),
    .PC(PC), .BD(BD), .ExcCode(ExcCode), .VAddr(VAddr), .HWInt(HWInt), .EXLClr(EXLClr),
    .IntReq(IntReq), .EPC(EPC), .Dout(Dout));
  always #10 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      A1 = e.a;
      #1;
      checks++;
      if (Dout !== e.v) begin
        errors++;
        $display("FAIL %s Dout=%h want %h", e.n, Dout, e.v);
      end
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    reset = 0;
    sb.push_back('{5'd12, 32'h0, "rst_sr"});
    sb.push_back('{5'd13, 32'h0, "rst_cause"});
    sb.push_back('{5'd14, 32'h0, "rst_epc"});
    sb.push_back('{5'd15, PRID, "rst_prid"});
    sb.push_back('{5'd8, 32'h0, "rst_bva"});
    #1;
    checks++;
    if (IntReq !== 1'b0) begin errors++; $display("FAIL rst_intreq IntReq=%b want 0", IntReq); end
    drain();
  endtask
  task automatic test_timer_int();
    @(negedge clk);
    WE = 1; A2 = 12; Din = 32'h0000_0401;
    @(negedge clk);
    WE = 0; HWInt = 6'b000001; PC = 30'h0C01; BD = 0;
    #1;
    checks++;
    if (IntReq !== 1'b1) begin errors++; $display("FAIL timer_intreq IntReq=%b want 1", IntReq); end
    @(negedge clk);
    HWInt = 0;
    sb.push_back('{5'd13, 32'h0000_0400, "timer_cause"});
    sb.push_back('{5'd14, {30'h0C01, 2'b00}, "timer_epc"});
    sb.push_back('{5'd12, 32'h0000_0403, "timer_sr"});
    #1;
    checks++;
    if (IntReq !== 1'b0 || EPC !== 30'h0C01) begin
      errors++; $display("FAIL timer_after IntReq=%b EPC=%h want 0 0c01", IntReq, EPC);
    end
    drain();
  endtask
  task automatic test_delay_slot_exc();
    @(negedge clk);
    WE = 1; A2 = 12; Din = 32'h0;
    @(negedge clk);
    WE = 0; ExcCode = 5'd10; BD = 1; PC = 30'h0C10;
    #1;
    checks++;
    if (IntReq !== 1'b1) begin errors++; $display("FAIL ds_intreq IntReq=%b want 1", IntReq); end
    @(negedge clk);
    ExcCode = 0; BD = 0;
    sb.push_back('{5'd13, 32'h8000_0028, "ds_cause"});
    sb.push_back('{5'd14, {30'h0C0F, 2'b00}, "ds_epc"});
    sb.push_back('{5'd12, 32'h0000_0002, "ds_sr"});
    drain();
  endtask
  task automatic test_simultaneous();
    @(negedge clk);
    WE = 1; A2 = 12; Din = 32'h0000_0801;
    @(negedge clk);
    HWInt = 6'b000010; ExcCode = 5'd4; A2 = 14; Din = 32'hFFFF_FFFC; PC = 30'h1234; VAddr = 32'hDEAD_0000;
    #1;
    checks++;
    if (IntReq !== 1'b1) begin errors++; $display("FAIL sim_intreq IntReq=%b want 1", IntReq); end
    @(negedge clk);
    WE = 0; HWInt = 0; ExcCode = 0; VAddr = 0;
    sb.push_back('{5'd13, 32'h0000_0800, "sim_cause"});
    sb.push_back('{5'd14, {30'h1234, 2'b00}, "sim_epc"});
    sb.push_back('{5'd12, 32'h0000_0803, "sim_sr"});
    sb.push_back('{5'd8, 32'h0, "sim_bva"});
    drain();
  endtask
  task automatic test_eret();
    @(negedge clk);
    EXLClr = 1; WE = 1; A2 = 12; Din = 32'h0000_0403; HWInt = 6'b000001;
    #1;
    checks++;
    if (IntReq !== 1'b0) begin errors++; $display("FAIL eret_masked IntReq=%b want 0", IntReq); end
    @(negedge clk);
    EXLClr = 0; WE = 0;
    #1;
    checks++;
    if (IntReq !== 1'b1) begin errors++; $display("FAIL eret_rereq IntReq=%b want 1", IntReq); end
    sb.push_back('{5'd12, 32'h0000_0401, "eret_sr"});
    drain();
    @(negedge clk);
    HWInt = 0;
    sb.push_back('{5'd12, 32'h0000_0403, "eret_taken_sr"});
    drain();
    #2 reset = 1;
    #1;
    checks++;
    if (Dout !== 32'h0 || IntReq !== 1'b0 || EPC !== 30'h0) begin
      errors++; $display("FAIL async_reset Dout=%h IntReq=%b EPC=%h want 0 0 0", Dout, IntReq, EPC);
    end
    @(negedge clk);
    reset = 0;
  endtask
  task automatic test_badvaddr();
    @(negedge clk);
    ExcCode = 5'd4; VAddr = 32'h0000_7F0B; PC = 30'h100;
    #1;
    checks++;
    if (IntReq !== 1'b1) begin errors++; $display("FAIL bva_intreq IntReq=%b want 1", IntReq); end
    @(negedge clk);
    ExcCode = 5'd5; VAddr = 32'h1111_1110; WE = 1; A2 = 13; Din = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (IntReq !== 1'b0) begin errors++; $display("FAIL exl_mask IntReq=%b want 0", IntReq); end
    @(negedge clk);
    ExcCode = 0; VAddr = 0; WE = 0;
    sb.push_back('{5'd8, BVA, "bva_read"});
    sb.push_back('{5'd13, 32'h0000_0010, "bva_cause"});
    sb.push_back('{5'd14, {30'h100, 2'b00}, "bva_epc"});
    drain();
  endtask
  task automatic test_wrap();
    @(negedge clk);
    WE = 1; A2 = 12; Din = 32'h0;
    @(negedge clk);
    WE = 0; ExcCode = 5'd12; BD = 1; PC = 30'h0;
    @(negedge clk);
    ExcCode = 0; BD = 0;
    #1;
    checks++;
    if (EPC !== 30'h3FFF_FFFF) begin errors++; $display("FAIL epc_wrap EPC=%h want 3fffffff", EPC); end
    sb.push_back('{5'd13, 32'h8000_0030, "wrap_cause"});
    sb.push_back('{5'd9, 32'h0, "unmapped"});
    drain();
  endtask
  initial begin
    test_reset();
    test_timer_int();
    test_delay_slot_exc();
    test_simultaneous();
    test_eret();
    test_badvaddr();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
